// File: rtl/case3_sweep_pkg.sv
// Shared types, constants and the golden case3 model for the sweep controller.
package case3_sweep_pkg;

    localparam int VEC_W = 7;
    localparam int NVEC  = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sweep_state_e;

    // Reference behaviour of the case3 netlist. vec = {a,b,c,d,e,f,g}, result = {x,y,z}.
    function automatic logic [2:0] case3_golden(input logic [VEC_W-1:0] vec);
        logic a, b, c, d, e, f, g;
        logic x, y, z;
        {a, b, c, d, e, f, g} = vec;
        x = a & b & c & d & e;
        y = b | c | (d ^ f) | (e ^ g);
        z = d ^ ((a & b & e & g) | (c & ~(e & g)));
        return {x, y, z};
    endfunction

endpackage

// File: rtl/case3_sweep_dly.sv
// Valid+vector shift register that lines launched vectors up with the DUT response.
// At DEPTH=0 it is a pure pass-through and never holds anything.
module case3_sweep_dly
    import case3_sweep_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_valid_i,
    input  logic [VEC_W-1:0] push_vec_i,
    output logic             tail_valid_o,
    output logic [VEC_W-1:0] tail_vec_o,
    output logic             pending_o
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign tail_valid_o = push_valid_i;
            assign tail_vec_o   = push_vec_i;
            assign pending_o    = 1'b0;
        end else begin : g_shift
            logic [DEPTH-1:0]            valid_q;
            logic [DEPTH-1:0][VEC_W-1:0] vec_q;

            // Shift every cycle; bubbles are pushed as valid=0, flush empties the line.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= '0;
                    vec_q   <= '0;
                end else if (flush_i) begin
                    valid_q <= '0;
                    vec_q   <= '0;
                end else begin
                    valid_q[0] <= push_valid_i;
                    vec_q[0]   <= push_vec_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        valid_q[i] <= valid_q[i-1];
                        vec_q[i]   <= vec_q[i-1];
                    end
                end
            end

            assign tail_valid_o = valid_q[DEPTH-1];
            assign tail_vec_o   = vec_q[DEPTH-1];
            assign pending_o    = |valid_q;
        end
    endgenerate

endmodule

// File: rtl/case3_sweep_ctrl.sv
// Exhaustive sweep controller: walks all 128 case3 input vectors, compares the
// DUT response against the golden model and keeps pass/fail and first-failure data.
module case3_sweep_ctrl
    import case3_sweep_pkg::*;
#(
    parameter int PIPE_LAT = 1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             hold,
    output logic [VEC_W-1:0] vec_o,
    input  logic             dut_x,
    input  logic             dut_y,
    input  logic             dut_z,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [VEC_W-1:0] first_err_vec,
    output logic [2:0]       first_err_obs
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NVEC - 1);

    sweep_state_e     state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [VEC_W-1:0] first_vec_q, first_vec_d;
    logic [2:0]       first_obs_q, first_obs_d;

    logic             push_valid;
    logic             flush;
    logic             cmp_valid;
    logic [VEC_W-1:0] cmp_vec;
    logic             dly_pending;
    logic [2:0]       observed;
    logic             mismatch;

    // A vector is launched on every un-held SWEEP cycle; abort empties the delay line.
    assign push_valid = (state_q == SWEEP) && !hold;
    assign flush      = abort && (state_q != IDLE);

    case3_sweep_dly #(
        .DEPTH (PIPE_LAT)
    ) u_dly (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .push_valid_i (push_valid),
        .push_vec_i   (vec_q),
        .tail_valid_o (cmp_valid),
        .tail_vec_o   (cmp_vec),
        .pending_o    (dly_pending)
    );

    assign observed = {dut_x, dut_y, dut_z};
    assign mismatch = cmp_valid && (observed != case3_golden(cmp_vec));

    // Next-state, vector counter and result bookkeeping.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        err_cnt_d   = err_cnt_q;
        first_vec_d = first_vec_q;
        first_obs_d = first_obs_q;

        if (mismatch) begin
            if (err_cnt_q != CNT_MAX) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            if (err_cnt_q == '0) begin
                first_vec_d = cmp_vec;
                first_obs_d = observed;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SWEEP;
                    vec_d       = '0;
                    err_cnt_d   = '0;
                    first_vec_d = '0;
                    first_obs_d = '0;
                end
            end
            SWEEP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!hold) begin
                    if (vec_q == LAST_VEC) begin
                        state_d = DRAIN;
                    end else begin
                        vec_d = vec_q + VEC_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!dly_pending) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d     = SWEEP;
                    vec_d       = '0;
                    err_cnt_d   = '0;
                    first_vec_d = '0;
                    first_obs_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            err_cnt_q   <= '0;
            first_vec_q <= '0;
            first_obs_q <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            err_cnt_q   <= err_cnt_d;
            first_vec_q <= first_vec_d;
            first_obs_q <= first_obs_d;
        end
    end

    assign vec_o         = vec_q;
    assign busy          = (state_q == SWEEP) || (state_q == DRAIN);
    assign done          = (state_q == DONE);
    assign pass          = (state_q == DONE) && (err_cnt_q == '0);
    assign err_cnt       = err_cnt_q;
    assign first_err_vec = first_vec_q;
    assign first_err_obs = first_obs_q;

endmodule

// File: tb/tb_case3_sweep_ctrl.sv
// Testbench for case3_sweep_ctrl: two controllers (one-cycle and combinational DUT
// latency, wide and narrow counters) share controls and sweep a modelled case3 DUT.
module tb_case3_sweep_ctrl;

   localparam int LatA = 1;
   localparam int CntA = 8;
   localparam int LatB = 0;
   localparam int CntB = 4;
   localparam int SatB = (1 << CntB) - 1;

   typedef struct {
      int fault;
      int holdMode;
      int expErr;
      int expFv;
      int expFo;
   } sweep_vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic hold = 1'b0;

   logic [6:0] vecA, vecB;
   logic [2:0] respA, respB;
   logic busyA, doneA, passA, busyB, doneB, passB;
   logic [CntA-1:0] errA;
   logic [CntB-1:0] errB;
   logic [6:0] fvA, fvB;
   logic [2:0] foA, foB;

   int faultKind = 0;
   logic [2:0] faultMask [128];
   int checks = 0;
   int errors = 0;

   // Free-running clock
   always #5 clk = ~clk;

   case3_sweep_ctrl #(.PIPE_LAT(LatA), .CNT_W(CntA)) dutA (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
      .vec_o(vecA), .dut_x(respA[2]), .dut_y(respA[1]), .dut_z(respA[0]),
      .busy(busyA), .done(doneA), .pass(passA), .err_cnt(errA),
      .first_err_vec(fvA), .first_err_obs(foA));

   case3_sweep_ctrl #(.PIPE_LAT(LatB), .CNT_W(CntB)) dutB (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
      .vec_o(vecB), .dut_x(respB[2]), .dut_y(respB[1]), .dut_z(respB[0]),
      .busy(busyB), .done(doneB), .pass(passB), .err_cnt(errB),
      .first_err_vec(fvB), .first_err_obs(foB));

   // Modelled netlist for dutA answers one cycle after the vector appears
   always @(posedge clk) respA <= dutModel(vecA, faultKind, faultMask[vecA]);

   // Modelled netlist for dutB answers combinationally
   assign respB = dutModel(vecB, faultKind, faultMask[vecB]);

   // Case3 truth written straight from the boolean equations, bit-indexed {a..g}
   function automatic logic [2:0] refGolden(input logic [6:0] v);
      logic x, y, z;
      x = (v[6:2] == 5'b11111);
      y = (v[5:4] != 2'b00) || (v[3] != v[1]) || (v[2] != v[0]);
      z = v[3] ^ ((v[6] && v[5] && v[2] && v[0]) || (v[4] && !(v[2] && v[0])));
      return {x, y, z};
   endfunction

   // Faulty netlist: 0 good, 1 y stuck-0, 2 x stuck-1, 3 z inverted, 4 per-vector xor mask
   function automatic logic [2:0] dutModel(input logic [6:0] v, input int kind, input logic [2:0] mask);
      logic [2:0] r;
      r = refGolden(v);
      case (kind)
         1: r[1] = 1'b0;
         2: r[2] = 1'b1;
         3: r[0] = ~r[0];
         4: r = r ^ mask;
         default: ;
      endcase
      return r;
   endfunction

   // Drive one set of inputs across one clock edge, then settle 1 time unit
   task automatic applyStimulus(input logic s, input logic a, input logic h);
      start = s;
      abort = a;
      hold  = h;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      hold  = 1'b0;
   endtask

   // Compare one observed value against its expectation
   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Count mismatching vectors over a whole sweep for the current fault set
   task automatic modelSweep(output sweep_vec_t sv);
      logic [2:0] obs;
      logic [6:0] v7;
      sv = '{fault: 4, holdMode: 2, expErr: 0, expFv: 0, expFo: 0};
      for (int v = 0; v < 128; v++) begin
         v7 = 7'(v);
         obs = dutModel(v7, 4, faultMask[v]);
         if (obs != refGolden(v7)) begin
            if (sv.expErr == 0) begin
               sv.expFv = v;
               sv.expFo = int'(obs);
            end
            sv.expErr++;
         end
      end
   endtask

   // Full sweep from IDLE/DONE with per-cycle vector, busy and done tracking
   task automatic runSweep(input sweep_vec_t sv);
      int launched, cyc, sweepEnd, expVec, expErrB;
      bit h, expBusyA, expBusyB;
      launched = 0;
      cyc = 0;
      sweepEnd = -1;
      faultKind = sv.fault;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("vec_at_start", int'(vecA), 0);
      checkOutput("busy_at_start", int'(busyA), 1);
      checkOutput("done_clr_at_start", int'(doneA), 0);
      checkOutput("err_clr_at_start", int'(errA), 0);
      while ((sweepEnd < 0 || cyc < sweepEnd + LatA + 2) && cyc < 5000) begin
         case (sv.holdMode)
            1: h = (cyc % 2) == 1;
            2: h = ($urandom_range(0, 2) == 0);
            default: h = 1'b0;
         endcase
         applyStimulus(1'b0, 1'b0, h);
         cyc++;
         if (sweepEnd < 0 && !h) begin
            launched++;
            if (launched == 128) sweepEnd = cyc;
         end
         expVec = (launched > 127) ? 127 : launched;
         expBusyA = (sweepEnd < 0) || (cyc < sweepEnd + LatA + 1);
         expBusyB = (sweepEnd < 0) || (cyc < sweepEnd + LatB + 1);
         checkOutput("vecA", int'(vecA), expVec);
         checkOutput("vecB", int'(vecB), expVec);
         checkOutput("busyA", int'(busyA), int'(expBusyA));
         checkOutput("doneA", int'(doneA), int'(!expBusyA));
         checkOutput("busyB", int'(busyB), int'(expBusyB));
         checkOutput("doneB", int'(doneB), int'(!expBusyB));
      end
      expErrB = (sv.expErr > SatB) ? SatB : sv.expErr;
      checkOutput("errA", int'(errA), sv.expErr);
      checkOutput("errB", int'(errB), expErrB);
      checkOutput("firstVecA", int'(fvA), sv.expFv);
      checkOutput("firstObsA", int'(foA), sv.expFo);
      checkOutput("firstVecB", int'(fvB), sv.expFv);
      checkOutput("firstObsB", int'(foB), sv.expFo);
      checkOutput("passA", int'(passA), int'(sv.expErr == 0));
      checkOutput("passB", int'(passB), int'(sv.expErr == 0));
   endtask

   // Safety net in case the clocked sequence stops advancing
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog expired before summary");
      $fatal(1, "[TB] watchdog");
   end

   // Main sequence: reset, vector table, hand-written corner cases, random sweeps
   initial begin
      sweep_vec_t sweepTable [5];
      sweep_vec_t sv;
      for (int i = 0; i < 128; i++) faultMask[i] = 3'b000;
      sweepTable[0] = '{fault: 0, holdMode: 0, expErr: 0,   expFv: 0, expFo: 0};
      sweepTable[1] = '{fault: 1, holdMode: 0, expErr: 120, expFv: 1, expFo: 0};
      sweepTable[2] = '{fault: 2, holdMode: 1, expErr: 124, expFv: 0, expFo: 4};
      sweepTable[3] = '{fault: 3, holdMode: 2, expErr: 128, expFv: 0, expFo: 1};
      sweepTable[4] = '{fault: 0, holdMode: 1, expErr: 0,   expFv: 0, expFo: 0};

      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("rst_vecA", int'(vecA), 0);
      checkOutput("rst_busyA", int'(busyA), 0);
      checkOutput("rst_doneA", int'(doneA), 0);
      checkOutput("rst_passA", int'(passA), 0);
      checkOutput("rst_errA", int'(errA), 0);
      checkOutput("rst_fvA", int'(fvA), 0);
      checkOutput("rst_foA", int'(foA), 0);
      checkOutput("rst_vecB", int'(vecB), 0);
      checkOutput("rst_errB", int'(errB), 0);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("idle_busyA", int'(busyA), 0);

      for (int i = 0; i < 5; i++) begin
         $display("[TB] table sweep %0d fault %0d hold mode %0d", i, sweepTable[i].fault, sweepTable[i].holdMode);
         runSweep(sweepTable[i]);
      end

      $display("[TB] abort from DONE keeps results");
      runSweep(sweepTable[1]);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("abortDone_done", int'(doneA), 0);
      checkOutput("abortDone_pass", int'(passA), 0);
      checkOutput("abortDone_busy", int'(busyA), 0);
      checkOutput("abortDone_errA", int'(errA), 120);
      checkOutput("abortDone_fvA", int'(fvA), 1);
      checkOutput("abortDone_errB", int'(errB), SatB);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("abortIdle_busy", int'(busyA), 0);
      checkOutput("abortIdle_errA", int'(errA), 120);
      checkOutput("abortIdle_vecA", int'(vecA), 127);

      $display("[TB] abort at vector 50");
      faultKind = 0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (50) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("pre_abort_vecA", int'(vecA), 50);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("abort50_busyA", int'(busyA), 0);
      checkOutput("abort50_doneA", int'(doneA), 0);
      checkOutput("abort50_busyB", int'(busyB), 0);
      checkOutput("abort50_vecA", int'(vecA), 50);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("abort50_vec_frozen", int'(vecA), 50);
      runSweep(sweepTable[0]);

      $display("[TB] start and abort together");
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("startAbort_busyA", int'(busyA), 0);
      checkOutput("startAbort_vecA", int'(vecA), 5);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("startAbort_idle", int'(busyA), 0);

      $display("[TB] start mid-sweep, then async reset");
      faultKind = 3;
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("mid_vecA", int'(vecA), 10);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("midStart_vecA", int'(vecA), 11);
      checkOutput("midStart_busyA", int'(busyA), 1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("midStart_vec_next", int'(vecA), 12);
      checkOutput("mid_errA", int'(errA), 12 - LatA);
      checkOutput("mid_errB", int'(errB), (12 - LatB > SatB) ? SatB : 12 - LatB);
      rst = 1'b1;
      #2;
      checkOutput("async_vecA", int'(vecA), 0);
      checkOutput("async_busyA", int'(busyA), 0);
      checkOutput("async_errA", int'(errA), 0);
      checkOutput("async_foA", int'(foA), 0);
      checkOutput("async_busyB", int'(busyB), 0);
      checkOutput("async_errB", int'(errB), 0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("post_rst_idle", int'(busyA), 0);
      faultKind = 0;

      for (int r = 0; r < 3; r++) begin
         for (int v = 0; v < 128; v++) begin
            faultMask[v] = ($urandom_range(0, 15) < 3) ? 3'($urandom_range(1, 7)) : 3'b000;
         end
         modelSweep(sv);
         $display("[TB] random sweep %0d expecting %0d mismatches", r, sv.expErr);
         runSweep(sv);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
